rxll_frame_sched: RTL and testbench

- Link-layer RX frame sequencer between the 36-bit SATA RX FIFO read port and the transport-layer FIS consumer.
- Starts a read only when a complete frame is buffered, checks SOF/EOF framing, enforces a maximum FIS length and drains bad frames.
- Presents frames on a registered valid/ready stream and reports per-frame status: length, FIS type and error code.

---
 rtl/rxll_frame_sched.sv | 147 ++++++++++++++
 tb/tb_rxll_frame_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rxll_frame_sched.sv
// rtl/rxll_frame_sched.sv - RX link-layer frame sequencer between the RX FIFO and the FIS stream
`timescale 1ns/1ps
module rxll_frame_sched #(
    parameter int C_LEN_W  = 12,
    parameter int C_MAX_DW = 2049
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               phyreset,
    input  logic               enable,
    input  logic [35:0]        rd_do,
    input  logic               rd_empty,
    input  logic               rd_eof_rdy,
    output logic               rd_en,
    output logic [31:0]        m_data,
    output logic               m_sof,
    output logic               m_eof,
    output logic               m_err,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               frm_done,
    output logic [C_LEN_W-1:0] frm_len,
    output logic [1:0]         frm_err,
    output logic [7:0]         fis_type,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_XFER, S_DROP, S_DRAIN, S_DONE
    } state_t;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_NO_SOF   = 2'd1;
    localparam logic [1:0] ERR_TOO_LONG = 2'd2;

    state_t             state, state_nxt;
    logic [C_LEN_W-1:0] cnt, cnt_inc;
    logic [1:0]         err;
    logic               sof_in, eof_in, accept, hit_max, load, trunc;
    logic               rd_unused;

    assign sof_in    = rd_do[35];
    assign eof_in    = rd_do[34];
    assign rd_unused = |rd_do[33:32];
    assign accept    = m_valid & m_ready;
    assign cnt_inc   = (&cnt) ? cnt : cnt + C_LEN_W'(1);
    assign hit_max   = (cnt_inc == C_LEN_W'(C_MAX_DW));
    assign busy      = (state != S_IDLE);

    // A beat is forwarded for the SOF word and for every word popped in XFER.
    assign load  = rd_en & (((state == S_START) & sof_in) | (state == S_XFER));
    assign trunc = rd_en & (state == S_XFER) & !eof_in & hit_max;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (enable & rd_eof_rdy & !rd_empty & !m_valid) state_nxt = S_START;
            end
            S_START: begin
                if (rd_en) begin
                    if (sof_in) state_nxt = eof_in ? S_DRAIN : S_XFER;
                    else        state_nxt = eof_in ? S_DONE  : S_DROP;
                end
            end
            S_XFER: begin
                if (rd_en & eof_in)  state_nxt = S_DRAIN;
                else if (trunc)      state_nxt = S_DROP;
            end
            S_DROP: begin
                if (rd_en & eof_in) state_nxt = m_valid ? S_DRAIN : S_DONE;
            end
            // The EOF beat may already have been taken on the cycle we arrived here.
            S_DRAIN: begin
                if (!m_valid | m_ready) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (phyreset) state_nxt = S_IDLE;
    end

    always_comb begin
        rd_en = 1'b0;
        if (!phyreset) begin
            case (state)
                S_START: rd_en = !rd_empty;
                S_XFER:  rd_en = !rd_empty & (!m_valid | m_ready);
                S_DROP:  rd_en = !rd_empty;
                default: rd_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_sof    <= 1'b0;
            m_eof    <= 1'b0;
            m_err    <= 1'b0;
            frm_done <= 1'b0;
            frm_len  <= '0;
            frm_err  <= ERR_OK;
            fis_type <= '0;
            cnt      <= '0;
            err      <= ERR_OK;
        end else if (phyreset) begin
            m_valid  <= 1'b0;
            frm_done <= 1'b0;
            cnt      <= '0;
            err      <= ERR_OK;
        end else begin
            frm_done <= (state == S_DONE);
            if (load) begin
                m_valid <= 1'b1;
                m_data  <= rd_do[31:0];
                m_sof   <= (state == S_START);
                m_eof   <= eof_in | trunc;
                m_err   <= trunc;
            end else if (accept) begin
                m_valid <= 1'b0;
            end
            if (rd_en) begin
                cnt <= (state == S_START) ? C_LEN_W'(1) : cnt_inc;
                if ((state == S_START) & !sof_in) err <= ERR_NO_SOF;
                if (trunc) err <= ERR_TOO_LONG;
            end
            if (rd_en & (state == S_START) & sof_in) fis_type <= rd_do[7:0];
            if (state == S_DONE) begin
                frm_len <= cnt;
                frm_err <= err;
                cnt     <= '0;
                err     <= ERR_OK;
            end
        end
    end

endmodule

// File: tb/tb_rxll_frame_sched.sv
// tb/tb_rxll_frame_sched.sv - randomized self-checking bench for rxll_frame_sched
`timescale 1ns/1ps
module tb_rxll_frame_sched;
    localparam int LW    = 12;
    localparam int MAXDW = 8;

    logic sys_clk = 1'b0;
    logic sys_rst, phyreset, enable, rd_empty, rd_eof_rdy, rd_en;
    logic m_sof, m_eof, m_err, m_valid, m_ready, frm_done, busy;
    logic [35:0]   rd_do;
    logic [31:0]   m_data;
    logic [LW-1:0] frm_len;
    logic [1:0]    frm_err;
    logic [7:0]    fis_type;

    rxll_frame_sched #(.C_LEN_W(LW), .C_MAX_DW(MAXDW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .phyreset(phyreset), .enable(enable),
        .rd_do(rd_do), .rd_empty(rd_empty), .rd_eof_rdy(rd_eof_rdy), .rd_en(rd_en),
        .m_data(m_data), .m_sof(m_sof), .m_eof(m_eof), .m_err(m_err),
        .m_valid(m_valid), .m_ready(m_ready), .frm_done(frm_done), .frm_len(frm_len),
        .frm_err(frm_err), .fis_type(fis_type), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct { logic [31:0] data; logic sof; logic eof; logic err; int id; } beat_t;
    typedef struct { int len; int err; logic [7:0] fis; int id; } stat_t;

    logic [35:0] fifo[$];
    beat_t       exp_b[$];
    stat_t       exp_s[$];
    logic [7:0]  model_fis = 8'h0;
    int          frame_id = 0;

    int errors = 0, checks = 0;
    int done_cnt = 0, beats_acc = 0, cyc = 0;
    int obs_len_q[$], obs_err_q[$], beat_cyc[$];
    logic [2:0] flags_q[$];
    bit   chk_en = 0, bp_check = 0;
    int   rdy_mode = 0, en_mode = 0;
    logic pv_stall = 1'b0;
    logic [34:0] pv_beat;
    beat_t cb;
    stat_t cs;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk(name, {rd_en, m_valid, m_sof, m_eof, m_err, m_data, frm_done,
                   frm_len, frm_err, fis_type, busy}, 0);
    endtask

    function automatic void drive_fifo();
        rd_empty   = (fifo.size() == 0);
        rd_do      = rd_empty ? 36'h0 : fifo[0];
        rd_eof_rdy = 1'b0;
        foreach (fifo[i]) if (fifo[i][34]) rd_eof_rdy = 1'b1;
    endfunction

    // Reference: a good frame forwards its first min(n, MAXDW) words; truncation marks the last one.
    task automatic push_frame(input int n, input bit sof, input logic [31:0] w0);
        logic [31:0] d;
        beat_t b;
        stat_t s;
        frame_id++;
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? w0 : 32'($urandom);
            if (sof && i < MAXDW) begin
                b.data = d;
                b.sof  = (i == 0);
                b.eof  = (i == n - 1) || (i == MAXDW - 1);
                b.err  = (i == MAXDW - 1) && (i != n - 1);
                b.id   = frame_id;
                exp_b.push_back(b);
            end
            fifo.push_back({(i == 0) ? sof : 1'($urandom_range(0, 1)), (i == n - 1),
                            2'($urandom_range(0, 3)), d});
        end
        if (sof) model_fis = w0[7:0];
        s.len = n;
        s.err = !sof ? 1 : ((n > MAXDW) ? 2 : 0);
        s.fis = model_fis;
        s.id  = frame_id;
        exp_s.push_back(s);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_s.size() != 0 || fifo.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("wait_idle_timeout", n >= budget, 0);
        repeat (2) step();
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (beats_acc < target && n < 200) begin
            step();
            n++;
        end
        chk("wait_beats_timeout", n >= 200, 0);
    endtask

    task automatic flush_model();
        fifo.delete();
        exp_b.delete();
        exp_s.delete();
    endtask

    // FWFT FIFO model: pop decided by rd_en seen at the falling edge.
    initial begin
        rd_do = '0; rd_empty = 1'b1; rd_eof_rdy = 1'b0;
        forever begin
            logic p;
            @(negedge sys_clk);
            p = rd_en;
            @(posedge sys_clk);
            #1;
            if (p && fifo.size() > 0) void'(fifo.pop_front());
            drive_fifo();
        end
    end

    always @(posedge sys_clk) cyc++;

    always begin
        @(posedge sys_clk);
        #2;
        if (rdy_mode == 0)      m_ready = 1'b1;
        else if (rdy_mode == 1) m_ready = !m_ready;
        else                    m_ready = ($urandom_range(0, 99) < 60);
        enable = (en_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
    end

    always @(negedge sys_clk) begin
        if (chk_en && !sys_rst && !phyreset) begin
            if (rd_en) chk("rd_en_while_empty", rd_empty, 0);
            if (bp_check && rd_en) chk("rd_en_while_stalled", m_valid & !m_ready, 0);
            if (pv_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_beat", {m_sof, m_eof, m_err, m_data}, pv_beat);
            end
            if (m_valid && m_ready) begin
                if (exp_b.size() == 0) chk("spurious_beat", 1, 0);
                else begin
                    cb = exp_b.pop_front();
                    chk("beat", {m_sof, m_eof, m_err, m_data}, {cb.sof, cb.eof, cb.err, cb.data});
                end
                beats_acc++;
                beat_cyc.push_back(cyc);
                flags_q.push_back({m_sof, m_eof, m_err});
            end
            if (frm_done) begin
                if (exp_s.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    cs = exp_s.pop_front();
                    chk("frm_len", frm_len, cs.len);
                    chk("frm_err", frm_err, cs.err);
                    chk("fis_type", fis_type, cs.fis);
                    chk("beats_left", exp_b.size() > 0 && exp_b[0].id == cs.id, 0);
                end
                done_cnt++;
                obs_len_q.push_back(int'(frm_len));
                obs_err_q.push_back(int'(frm_err));
            end
            pv_stall = m_valid & !m_ready;
            pv_beat  = {m_sof, m_eof, m_err, m_data};
        end else begin
            pv_stall = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, b0, n;
        sys_rst = 1'b1; phyreset = 1'b0; enable = 1'b0; m_ready = 1'b0;
        repeat (3) step();
        chk_reset_vals("reset_values");
        sys_rst = 1'b0;
        chk_en  = 1;
        step();

        // Normal 5-dword FIS at full rate
        d0 = done_cnt; beat_cyc.delete(); obs_len_q.delete(); obs_err_q.delete();
        push_frame(5, 1, 32'h0000_0046);
        wait_idle(200);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_len", obs_len_q.size() > 0 ? obs_len_q[$] : -1, 5);
        chk("t1_err", obs_err_q.size() > 0 ? obs_err_q[$] : -1, 0);
        chk("t1_fis", fis_type, 8'h46);
        chk("t1_beats", beat_cyc.size(), 5);
        if (beat_cyc.size() == 5) chk("t1_consecutive", beat_cyc[4] - beat_cyc[0], 4);

        // Backpressure with m_ready toggling every clock
        rdy_mode = 1; bp_check = 1; b0 = beats_acc; obs_len_q.delete();
        push_frame(5, 1, 32'($urandom));
        wait_idle(300);
        bp_check = 0; rdy_mode = 0;
        chk("t2_beats", beats_acc - b0, 5);
        chk("t2_len", obs_len_q.size() > 0 ? obs_len_q[$] : -1, 5);

        // NO_SOF frame followed by a good one
        b0 = beats_acc; obs_len_q.delete(); obs_err_q.delete();
        push_frame(3, 0, 32'($urandom));
        push_frame(4, 1, 32'($urandom));
        wait_idle(300);
        chk("t3_beats", beats_acc - b0, 4);
        chk("t3_dones", obs_len_q.size(), 2);
        if (obs_len_q.size() == 2) begin
            chk("t3_nosof_len", obs_len_q[0], 3);
            chk("t3_nosof_err", obs_err_q[0], 1);
            chk("t3_good_err", obs_err_q[1], 0);
        end

        // TOO_LONG: 12 words against an 8-dword limit
        b0 = beats_acc; obs_len_q.delete(); obs_err_q.delete(); flags_q.delete();
        push_frame(12, 1, 32'($urandom));
        wait_idle(300);
        chk("t4_beats", beats_acc - b0, 8);
        chk("t4_last_flags", flags_q.size() > 0 ? flags_q[$] : 3'b111, 3'b011);
        chk("t4_len", obs_len_q.size() > 0 ? obs_len_q[$] : -1, 12);
        chk("t4_err", obs_err_q.size() > 0 ? obs_err_q[$] : -1, 2);

        // Single-dword FIS back to back with a 2-dword FIS
        obs_len_q.delete(); flags_q.delete();
        push_frame(1, 1, 32'($urandom));
        push_frame(2, 1, 32'($urandom));
        wait_idle(300);
        chk("t5_first_flags", flags_q.size() > 0 ? flags_q[0] : 3'b111, 3'b110);
        chk("t5_dones", obs_len_q.size(), 2);
        if (obs_len_q.size() == 2) chk("t5_lens", obs_len_q[0] * 16 + obs_len_q[1], 16 + 2);

        // phyreset in the middle of a 6-dword frame
        d0 = done_cnt; b0 = beats_acc;
        push_frame(6, 1, 32'h1234_5627);
        wait_beats(b0 + 3);
        phyreset = 1'b1; chk_en = 0;
        flush_model();
        @(negedge sys_clk);
        chk("t6_rd_en_in_phyreset", rd_en, 0);
        step();
        phyreset = 1'b0;
        chk("t6_valid_cleared", m_valid, 0);
        chk("t6_busy_cleared", busy, 0);
        chk("t6_fis_kept", fis_type, 8'h27);
        chk_en = 1;
        repeat (5) step();
        chk("t6_no_done", done_cnt - d0, 0);
        obs_len_q.delete();
        push_frame(2, 1, 32'($urandom));
        wait_idle(200);
        chk("t6_after_len", obs_len_q.size() > 0 ? obs_len_q[$] : -1, 2);

        // Asynchronous sys_rst mid-frame
        b0 = beats_acc;
        push_frame(6, 1, 32'($urandom));
        wait_beats(b0 + 2);
        @(negedge sys_clk);
        #1;
        sys_rst = 1'b1; chk_en = 0;
        #1;
        chk_reset_vals("async_reset_values");
        flush_model();
        model_fis = 8'h0;
        repeat (2) step();
        sys_rst = 1'b0; chk_en = 1;
        step();

        // Randomized frames with random backpressure and enable
        rdy_mode = 2; en_mode = 1; d0 = done_cnt;
        for (int f = 0; f < 60; f++) begin
            n = $urandom_range(1, 12);
            push_frame(n, $urandom_range(0, 9) != 0, 32'($urandom));
            repeat ($urandom_range(0, 3)) step();
        end
        wait_idle(20000);
        chk("rand_done_count", done_cnt - d0, 60);
        chk("rand_beats_drained", exp_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
